dmem_wait_ctrl: RTL
===================

// Module: dmem_wait_ctrl
// PURPOSE
//  Parametrised data memory for the pipelined core, with configurable wait states.
//  Uses a request/response handshake and drives a stall output into the hazard unit.
//  Sits between the MEM-stage pipeline register and the storage array.
//  Supersedes the fixed 16-bit, zero-latency data memory.
// PARAMETERS
//  DATA_W       16   data word width; must be a multiple of 8 when DMEM_BYTE_EN is defined
//  ADDR_W       16   request address width; word-addressed
//  DEPTH        256  number of words; legal addresses are 0..DEPTH-1
//  WAIT_CYCLES  2    extra wait states before the array access; range 0..15
// PORTS
//  clk        in   1            clock, rising edge
//  reset      in   1            asynchronous, active-high reset
//  req_valid  in   1            MEM stage is requesting an access
//  req_write  in   1            1 = store, 0 = load
//  req_addr   in   ADDR_W       word address
//  req_wdata  in   DATA_W       store data
//  req_be     in   DATA_W/8     byte-lane write enables; present only with DMEM_BYTE_EN
//  req_ready  out  1            block is idle and can accept a request
//  rsp_valid  out  1            one-cycle completion pulse (load data or store ack)
//  rsp_rdata  out  DATA_W       load data; held until the next load completes
//  rsp_err    out  1            address out of range; qualified by rsp_valid
//  stall      out  1            hold PC/IF/ID/EX/MEM; goes to the hazard unit
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, counter=0, all outputs 0 except req_ready=1.
//   Array contents are not cleared.
//   A request that has not yet committed is dropped; a store still in WAIT never writes.
//  FSM:
//   IDLE: req_ready=1. If req_valid, latch write/addr/wdata(/be), set cnt=WAIT_CYCLES, go to WAIT.
//   WAIT: if cnt!=0, decrement.
//    If cnt==0, perform the array access at this edge and go to RESP.
//    A load registers rsp_rdata. A store writes the array.
//   RESP: rsp_valid=1 for exactly one cycle, then IDLE.
//  req_ready=1 only in IDLE. req_valid seen in RESP belongs to the same instruction and is ignored.
//  stall = (state==WAIT) | (state==IDLE & req_valid). stall is 0 in RESP, so the pipeline advances.
//  Latency: accept at edge E0; rsp_valid is high in the cycle after edge E0+WAIT_CYCLES+1.
//   A request occupies WAIT_CYCLES+3 cycles, including the IDLE accept cycle.
//  Range check: req_addr>=DEPTH gives no array access, rsp_err=1 with rsp_valid.
//   A faulting load returns rsp_rdata=0.
//   Only the low clog2(DEPTH) bits index the array.
//  Stores leave rsp_rdata unchanged.
//  Ordering is strictly in order, one access outstanding, so a load after a store returns the new data.
//  Debug task dump_memory prints every word as index:hex.
// CONFIGURATION
//  DMEM_BYTE_EN defined: req_be port exists.
//   A store writes only bytes with req_be[i]=1. A store with req_be=0 is a no-op but still acks.
//   Loads ignore req_be.
//  DMEM_BYTE_EN undefined: no req_be port; every store writes the full word.
// STRUCTURE
//  dmem_pkg: state localparams (IDLE=2'd0, WAIT=2'd1, RESP=2'd2) and a clog2 function for the index width.
//  Sub-module dmem_array: synchronous-write storage with a byte-lane mask and a registered read.
//   dump_memory lives here.
//  dmem_wait_ctrl: FSM, wait counter, request latch, range check, stall/ready decode.
// TESTING
//  Reset mid-WAIT during a store of 0xBEEF to addr 5.
//   -> state IDLE, req_ready=1, mem[5] unchanged.
//  WAIT_CYCLES=2: store 0x1234 to addr 3, then load from addr 3.
//   -> stall high 4 cycles per access.
//   -> rsp_valid pulses once each.
//   -> rsp_rdata=0x1234.
//  WAIT_CYCLES=0: back-to-back loads from addrs 0 and 1.
//   -> each completes 2 edges after accept.
//   -> no double accept while req_valid is held in RESP.
//  Load from addr 300 with DEPTH=256.
//   -> rsp_valid=1, rsp_err=1, rsp_rdata=0.
//   -> mem[44] neither read nor written.
//  DMEM_BYTE_EN: mem[7]=0xAAAA, store 0x5555 with be=2'b01.
//   -> mem[7]=0xAA55.
//   -> store with be=2'b00 leaves 0xAA55 but still acks.
//  DATA_W=32, DEPTH=1024, WAIT_CYCLES=5: store/load at addr 1023.
//   -> data matches.
//   -> rsp_valid 7 edges after accept.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the wait-state data memory: FSM state encoding,
// wait-counter width and an index-width helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // Wide enough for wait-state counts 0..15.
    localparam int CNT_W = 4;

    // Bits needed to index 'value' words; never less than one.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Storage array for dmem_wait_ctrl: synchronous write with a lane mask and a
// registered read port. A read can be forced to return zero without touching
// the array, which is used for out-of-range loads.
// Array contents have no reset; only the read register clears on reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int LANE_W = 8,
    parameter int LANES  = 2,
    parameter int DEPTH  = 256,
    localparam int DATA_W = LANE_W * LANES,
    localparam int IDX_W  = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [LANES-1:0]  wr_mask,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_en,
    input  logic              rd_zero,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;

    // Lane-masked write; lanes with a clear mask bit keep their old contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_mask[i]) begin
                    mem_q[idx][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Next read data: hold unless a read is issued; a zeroed read skips the array.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = rd_zero ? '0 : mem_q[idx];
        end
    end

    // Read data register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

`ifndef SYNTHESIS
    // Debug aid: print every word as index:hex.
    task automatic dump_memory();
        for (int i = 0; i < DEPTH; i++) begin
            $display("%0d:%h", i, mem_q[i]);
        end
    endtask
`endif

endmodule

// File: rtl/dmem_wait_ctrl.sv
// Data memory for the pipelined core with configurable wait states.
// Request/response handshake towards the MEM stage plus a stall output for
// the hazard unit. One access outstanding at a time, strictly in order.
// Optional feature macro: DMEM_BYTE_EN adds the req_be byte-lane write enables.
//
// state | meaning
// IDLE  | ready for a new request; req_valid is accepted and latched here
// WAIT  | counting down wait states; array accessed on the edge where cnt==0
// RESP  | one-cycle completion pulse on rsp_valid; pipeline advances
module dmem_wait_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
`ifdef DMEM_BYTE_EN
    input  logic [DATA_W/8-1:0] req_be,
`endif
    output logic                req_ready,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                stall
);

`ifdef DMEM_BYTE_EN
    localparam int LANES = DATA_W / 8;
`else
    localparam int LANES = 1;
`endif
    localparam int LANE_W = DATA_W / LANES;
    localparam int IDX_W  = clog2(DEPTH);

    dmem_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               write_q, write_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [LANES-1:0]   be_q, be_d;
    logic               err_q, err_d;

    logic               out_of_range;
    logic               arr_wr;
    logic               arr_rd;
    logic [LANES-1:0]   req_lanes;

`ifdef DMEM_BYTE_EN
    assign req_lanes = req_be;
`else
    assign req_lanes = '1;
`endif

    // Only the full latched address decides range; the array sees the low bits.
    assign out_of_range = (32'(addr_q) >= 32'(DEPTH));

    // Next-state, request latch and array access strobes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        err_d   = err_q;
        arr_wr  = 1'b0;
        arr_rd  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_lanes;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    err_d   = out_of_range;
                    arr_wr  = write_q & ~out_of_range;
                    arr_rd  = ~write_q;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and request latch registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            err_q   <= err_d;
        end
    end

    dmem_array #(
        .LANE_W (LANE_W),
        .LANES  (LANES),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (arr_wr),
        .wr_mask (be_q),
        .idx     (addr_q[IDX_W-1:0]),
        .wdata   (wdata_q),
        .rd_en   (arr_rd),
        .rd_zero (out_of_range),
        .rdata   (rsp_rdata)
    );

    // Handshake and stall decode; stall drops in RESP so the pipeline moves on.
    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        rsp_err   = (state_q == RESP) & err_q;
        stall     = (state_q == WAIT) | ((state_q == IDLE) & req_valid);
    end

endmodule
